// File: rtl/ds_dac_multi.sv
// Multi-channel first-order delta-sigma DAC. Frames enter a one-deep pending buffer via
// valid/ready and move to the modulators on each frame tick. An empty buffer at a tick is flagged as an underrun.
module ds_dac_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int RATE_DIV = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] sample,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      mute,
    output logic                      frame_tick,
    output logic                      underrun,
    output logic [CHANNELS-1:0]       analog
);

    localparam int                CNT_W    = $clog2(RATE_DIV);
    localparam int                ACC_W    = WIDTH + 2;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RATE_DIV - 1);
    localparam logic [WIDTH-1:0]  MID      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [ACC_W-1:0]  ACC_RST  = {2'b01, {WIDTH{1'b0}}};

    logic [CNT_W-1:0]                 r_cnt;
    logic                             r_pend_full;
    logic [CHANNELS-1:0][WIDTH-1:0]   r_pend;
    logic [CHANNELS-1:0][WIDTH-1:0]   r_act;
    logic [CHANNELS-1:0][ACC_W-1:0]   r_acc;
    logic                             r_frame_tick;
    logic                             r_underrun;
    logic                             w_tick;
    logic                             w_accept;

    // Feedback subtracts 2^WIDTH when the MSB is set (adding 3*2^WIDTH mod 2^(WIDTH+2)),
    // which keeps the accumulator within [2^WIDTH, 3*2^WIDTH).
    function automatic logic [ACC_W-1:0] mod_next(input logic [ACC_W-1:0] acc,
                                                  input logic [WIDTH-1:0] din);
        logic [ACC_W-1:0] fb;
        fb = {acc[ACC_W-1], acc[ACC_W-1], {WIDTH{1'b0}}};
        return acc + {2'b00, din} + fb;
    endfunction

    function automatic logic [WIDTH-1:0] mod_input(input logic m, input logic [WIDTH-1:0] act);
        return m ? MID : act;
    endfunction

    assign w_tick       = (r_cnt == CNT_LAST);
    assign w_accept     = sample_valid && !r_pend_full;
    assign sample_ready = !r_pend_full;
    assign frame_tick   = r_frame_tick;
    assign underrun     = r_underrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_pend_full  <= 1'b0;
            r_pend       <= {CHANNELS{MID}};
            r_act        <= {CHANNELS{MID}};
            r_acc        <= {CHANNELS{ACC_RST}};
            r_frame_tick <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_frame_tick <= w_tick;
            r_underrun   <= w_tick && !r_pend_full;
            // A tick with a full buffer blocks acceptance (ready is low), so the branches never collide.
            if (w_tick && r_pend_full) begin
                r_act       <= r_pend;
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pend      <= sample;
                r_pend_full <= 1'b1;
            end
            for (int n = 0; n < CHANNELS; n++) begin
                r_acc[n] <= mod_next(r_acc[n], mod_input(mute, r_act[n]));
            end
        end
    end

    always_comb begin
        analog = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            analog[n] = r_acc[n][ACC_W-1];
        end
    end

endmodule

// File: tb/tb_ds_dac_multi.sv
// Directed bench for ds_dac_multi (WIDTH=8, CHANNELS=2, RATE_DIV=256): reset pattern,
// density table, backpressure, tick/accept collision, mute and mid-frame reset.
module tb_ds_dac_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        mute;
    logic        frame_tick;
    logic        underrun;
    logic [1:0]  analog;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    ds_dac_multi #(.WIDTH(8), .CHANNELS(2), .RATE_DIV(256)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mute         (mute),
        .frame_tick   (frame_tick),
        .underrun     (underrun),
        .analog       (analog)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] d0;
        logic [7:0] d1;
        int         lo0;
        int         hi0;
        int         lo1;
        int         hi1;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    function automatic int next_bound(input int c);
        return ((c / 256) + 1) * 256;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d..%0d", name, cyc, act, lo, hi);
        end
    endtask

    task automatic count_win(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < n; i++) begin
            c0 += int'(analog[0]);
            c1 += int'(analog[1]);
            step();
        end
    endtask

    task automatic offer(input logic [7:0] d0, input logic [7:0] d1);
        chk("offer_ready_before", int'(sample_ready), 1);
        sample       = {d1, d0};
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("offer_ready_after", int'(sample_ready), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_analog"}, int'(analog), 0);
        chk({tag, "_ready"}, int'(sample_ready), 1);
        chk({tag, "_frame_tick"}, int'(frame_tick), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
    endtask

    initial begin
        int b;
        int c0;
        int c1;

        vecs[0] = '{"v_00_ff", 8'h00, 8'hFF, 0,   0,   255, 255};
        vecs[1] = '{"v_40_80", 8'h40, 8'h80, 63,  65,  127, 129};
        vecs[2] = '{"v_01_fe", 8'h01, 8'hFE, 0,   2,   253, 255};
        vecs[3] = '{"v_c0_20", 8'hC0, 8'h20, 191, 193, 31,  33};
        vecs[4] = '{"v_80_00", 8'h80, 8'h00, 127, 129, 0,   0};
        vecs[5] = '{"v_ff_40", 8'hFF, 8'h40, 255, 255, 63,  65};

        reset        = 1'b1;
        sample       = '0;
        sample_valid = 1'b0;
        mute         = 1'b0;
        step();
        step();
        check_reset_state("rst");
        reset = 1'b0;
        cyc   = 0;

        // Midscale idle pattern straight out of reset.
        for (int k = 0; k < 8; k++) begin
            chk("idle_seq", int'(analog), (k >= 2 && (k % 2) == 0) ? 3 : 0);
            step();
        end
        run_to(255);
        chk("idle_ur_pre", int'(underrun), 0);
        chk("idle_ft_pre", int'(frame_tick), 0);
        step();
        chk("idle_ur_256", int'(underrun), 1);
        chk("idle_ft_256", int'(frame_tick), 1);
        chk("idle_ready", int'(sample_ready), 1);
        step();
        chk("idle_ur_257", int'(underrun), 0);
        run_to(512);
        chk("idle_ur_512", int'(underrun), 1);
        step();

        foreach (vecs[i]) begin
            offer(vecs[i].d0, vecs[i].d1);
            b = next_bound(cyc);
            run_to(b);
            chk({vecs[i].name, "_no_ur"}, int'(underrun), 0);
            chk({vecs[i].name, "_ft"}, int'(frame_tick), 1);
            chk({vecs[i].name, "_ready"}, int'(sample_ready), 1);
            run_to(b + 1 + 512);
            count_win(256, c0, c1);
            chk_rng({vecs[i].name, "_ch0"}, c0, vecs[i].lo0, vecs[i].hi0);
            chk_rng({vecs[i].name, "_ch1"}, c1, vecs[i].lo1, vecs[i].hi1);
        end

        // Backpressure: A pending, B held valid until the buffer frees up.
        b = next_bound(cyc);
        offer(8'h00, 8'hFF);
        sample       = {8'h00, 8'hFF};
        sample_valid = 1'b1;
        step();
        chk("bp_ready_hold", int'(sample_ready), 0);
        run_to(b - 1);
        chk("bp_ready_pre_tick", int'(sample_ready), 0);
        step();
        chk("bp_ready_at_tick", int'(sample_ready), 1);
        chk("bp_no_ur", int'(underrun), 0);
        step();
        chk("bp_b_accepted", int'(sample_ready), 0);
        sample_valid = 1'b0;
        count_win(256, c0, c1);
        chk("bp_a_ch0", c0, 0);
        chk_rng("bp_a_ch1", c1, 254, 256);
        count_win(256, c0, c1);
        chk_rng("bp_b_ch0", c0, 254, 256);
        chk("bp_b_ch1", c1, 0);

        // Valid raised on the tick cycle with an empty buffer.
        b = next_bound(cyc);
        run_to(b - 1);
        chk("coll_ready_pre", int'(sample_ready), 1);
        sample       = {8'hFF, 8'h00};
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("coll_underrun", int'(underrun), 1);
        chk("coll_ft", int'(frame_tick), 1);
        chk("coll_accepted", int'(sample_ready), 0);
        run_to(b + 256);
        chk("coll_no_second_ur", int'(underrun), 0);
        chk("coll_ready_after", int'(sample_ready), 1);
        step();
        count_win(256, c0, c1);
        chk("coll_ch0", c0, 0);
        chk_rng("coll_ch1", c1, 254, 256);

        // Mute with ch0 full scale, then release.
        offer(8'hFF, 8'h00);
        b = next_bound(cyc);
        run_to(b);
        mute = 1'b1;
        run_to(b + 512);
        chk("mute_ready", int'(sample_ready), 1);
        count_win(256, c0, c1);
        chk_rng("mute_ch0", c0, 127, 129);
        chk_rng("mute_ch1", c1, 127, 129);
        mute = 1'b0;
        run_to(cyc + 512);
        count_win(256, c0, c1);
        chk("unmute_ch0", c0, 255);
        chk("unmute_ch1", c1, 0);

        // Mid-frame reset discards the pending frame and restarts the counter.
        run_to(next_bound(cyc) + 20);
        offer(8'h40, 8'h40);
        run_to(cyc + 50);
        chk("mid_ready_full", int'(sample_ready), 0);
        reset = 1'b1;
        step();
        check_reset_state("mid_rst");
        reset = 1'b0;
        cyc   = 0;
        for (int k = 0; k < 4; k++) begin
            chk("mid_seq", int'(analog), (k >= 2 && (k % 2) == 0) ? 3 : 0);
            step();
        end
        run_to(255);
        chk("mid_ft_pre", int'(frame_tick), 0);
        step();
        chk("mid_ft_256", int'(frame_tick), 1);
        chk("mid_ur_256", int'(underrun), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
